// File: rtl/comparador_serial_izq_der.sv
// Bit-serial MSB-first magnitude comparator behind a start/done handshake.
// Latency N cycles (full scan) or N-i cycles (early exit at bit i); start is ignored while busy.
module comparador_serial_izq_der #(
  parameter int N          = 3,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N-1:0]               A,
  input  logic [N-1:0]               B,
  input  logic [1:0]                 mode,
  output logic                       busy,
  output logic                       done,
  output logic                       Zout,
  output logic [$clog2(N+1)-1:0]     bits_used
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] NCNT = CW'(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  sa, sb;
  logic [1:0]    md;
  logic          eq, lt, gt;
  logic [CW-1:0] cnt;

  logic          sign_step, eq_n, lt_n, gt_n, finish, z_n;
  logic [CW-1:0] cnt_n;

  assign busy = (state == SCAN);
  assign done = (state == DONE);

  always_comb begin
    eq_n      = eq;
    lt_n      = lt;
    gt_n      = gt;
    // The sign bit is the first one consumed; a 1 there marks the smaller value.
    sign_step = (SIGNED != 0) && (cnt == '0);
    if (eq && (sa[N-1] != sb[N-1])) begin
      eq_n = 1'b0;
      if (sa[N-1] ^ sign_step) gt_n = 1'b1;
      else                     lt_n = 1'b1;
    end
    cnt_n  = cnt + 1'b1;
    finish = (cnt_n == NCNT) || ((EARLY_EXIT != 0) && !eq_n);
    case (md)
      2'b00:   z_n = lt_n | eq_n;
      2'b01:   z_n = lt_n;
      2'b10:   z_n = eq_n;
      default: z_n = gt_n | eq_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      md        <= '0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
      cnt       <= '0;
      Zout      <= 1'b0;
      bits_used <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= A;
            sb    <= B;
            md    <= mode;
            eq    <= 1'b1;
            lt    <= 1'b0;
            gt    <= 1'b0;
            cnt   <= '0;
            state <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          sa  <= sa << 1;
          sb  <= sb << 1;
          eq  <= eq_n;
          lt  <= lt_n;
          gt  <= gt_n;
          cnt <= cnt_n;
          if (finish) begin
            state     <= DONE;
            Zout      <= z_n;
            bits_used <= cnt_n;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Scoreboard bench: five comparator configurations driven side by side, results checked
// against a value-level model when each done pulse appears.
module tb_comparador_serial_izq_der;

  typedef struct {
    logic z;
    int   bits;
    int   cyc;
  } exp_t;

  localparam int PN[5] = '{3, 3, 3, 8, 8};
  localparam int PS[5] = '{0, 1, 0, 0, 1};
  localparam int PE[5] = '{0, 0, 1, 1, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] st = '0;
  logic [2:0] a3 = '0, b3 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] md = '0;

  logic       bz[5], dn[5], zo[5];
  logic [1:0] bu0, bu1, bu2;
  logic [3:0] bu3, bu4;
  logic [3:0] bu[5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[5][$];
  exp_t me;

  assign bu[0] = {2'b00, bu0};
  assign bu[1] = {2'b00, bu1};
  assign bu[2] = {2'b00, bu2};
  assign bu[3] = bu3;
  assign bu[4] = bu4;

  comparador_serial_izq_der #(.N(3), .SIGNED(0), .EARLY_EXIT(0)) u0 (
    .clk(clk), .reset(reset), .start(st[0]), .A(a3), .B(b3), .mode(md),
    .busy(bz[0]), .done(dn[0]), .Zout(zo[0]), .bits_used(bu0));
  comparador_serial_izq_der #(.N(3), .SIGNED(1), .EARLY_EXIT(0)) u1 (
    .clk(clk), .reset(reset), .start(st[1]), .A(a3), .B(b3), .mode(md),
    .busy(bz[1]), .done(dn[1]), .Zout(zo[1]), .bits_used(bu1));
  comparador_serial_izq_der #(.N(3), .SIGNED(0), .EARLY_EXIT(1)) u2 (
    .clk(clk), .reset(reset), .start(st[2]), .A(a3), .B(b3), .mode(md),
    .busy(bz[2]), .done(dn[2]), .Zout(zo[2]), .bits_used(bu2));
  comparador_serial_izq_der #(.N(8), .SIGNED(0), .EARLY_EXIT(1)) u3 (
    .clk(clk), .reset(reset), .start(st[3]), .A(a8), .B(b8), .mode(md),
    .busy(bz[3]), .done(dn[3]), .Zout(zo[3]), .bits_used(bu3));
  comparador_serial_izq_der #(.N(8), .SIGNED(1), .EARLY_EXIT(1)) u4 (
    .clk(clk), .reset(reset), .start(st[4]), .A(a8), .B(b8), .mode(md),
    .busy(bz[4]), .done(dn[4]), .Zout(zo[4]), .bits_used(bu4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Value-level reference: compare as integers, latency from first differing bit.
  function automatic exp_t model(input int i, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] m);
    exp_t r;
    int n, va, vb;
    n  = PN[i];
    va = int'(a);
    vb = int'(b);
    if (PS[i] != 0) begin
      if (a[n-1]) va -= (1 << n);
      if (b[n-1]) vb -= (1 << n);
    end
    case (m)
      2'b00:   r.z = (va <= vb);
      2'b01:   r.z = (va < vb);
      2'b10:   r.z = (va == vb);
      default: r.z = (va >= vb);
    endcase
    r.bits = n;
    if (PE[i] != 0) begin
      for (int k = n - 1; k >= 0; k--) begin
        if (a[k] != b[k]) begin
          r.bits = n - k;
          break;
        end
      end
    end
    r.cyc = r.bits;
    return r;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < 5; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        if (dn[i]) begin
          if (q[i].size() == 0) begin
            chk($sformatf("u%0d_spurious_done", i), 1, 0);
          end else begin
            me = q[i].pop_front();
            chk($sformatf("u%0d_zout", i), int'(zo[i]), int'(me.z));
            chk($sformatf("u%0d_bits_used", i), int'(bu[i]), me.bits);
            chk($sformatf("u%0d_latency_cycle", i), cyc, me.cyc);
          end
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic [2:0] a, input logic [2:0] b,
                          input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] m);
    exp_t e;
    if (i < 3) e = model(i, {5'b0, a}, {5'b0, b}, m);
    else       e = model(i, xa, xb, m);
    e.cyc = e.cyc + cyc;
    q[i].push_back(e);
  endtask

  task automatic start_op(input logic [4:0] mask, input logic [2:0] a, input logic [2:0] b,
                          input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] m,
                          input bit push);
    @(negedge clk);
    a3 = a; b3 = b; a8 = xa; b8 = xb; md = m; st = mask;
    @(posedge clk);
    #1;
    st = '0;
    if (push)
      for (int i = 0; i < 5; i++) if (mask[i]) push_exp(i, a, b, xa, xb, m);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && !all_empty(); k++) begin
      @(negedge clk);
      #2;
    end
    if (!all_empty()) begin
      chk("drain_timeout", 0, 1);
      for (int i = 0; i < 5; i++) q[i].delete();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_u%0d_busy", tag, i), int'(bz[i]), 0);
      chk($sformatf("%s_u%0d_done", tag, i), int'(dn[i]), 0);
      chk($sformatf("%s_u%0d_zout", tag, i), int'(zo[i]), 0);
      chk($sformatf("%s_u%0d_bits_used", tag, i), int'(bu[i]), 0);
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Corners, mode A<=B.
    start_op(5'b11111, 3'b111, 3'b111, 8'h3C, 8'h3C, 2'b00, 1'b1); drain();
    start_op(5'b11111, 3'b111, 3'b000, 8'hFF, 8'h00, 2'b00, 1'b1); drain();
    start_op(5'b11111, 3'b000, 3'b111, 8'h00, 8'hFF, 2'b00, 1'b1); drain();
    start_op(5'b11111, 3'b000, 3'b000, 8'h00, 8'h00, 2'b00, 1'b1); drain();

    // MSB differs on the 8-bit units: one-cycle early exit, sign flips the answer.
    start_op(5'b11111, 3'b100, 3'b011, 8'h80, 8'h7F, 2'b00, 1'b1); drain();

    // Reset during the second SCAN cycle abandons the operation silently.
    start_op(5'b11111, 3'b011, 3'b011, 8'h5A, 8'h5A, 2'b01, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy_u0", int'(bz[0]), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("midreset_u%0d_busy", i), int'(bz[i]), 0);
      chk($sformatf("midreset_u%0d_zout", i), int'(zo[i]), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    start_op(5'b11111, 3'b010, 3'b110, 8'h12, 8'h34, 2'b01, 1'b1); drain();

    // Back-to-back: start held high through DONE on u0.
    @(negedge clk);
    a3 = 3'b111; b3 = 3'b111; md = 2'b00; st = 5'b00001;
    @(posedge clk);
    #1;
    push_exp(0, 3'b111, 3'b111, 8'h00, 8'h00, 2'b00);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = dn[0];
    end
    if (!seen) chk("b2b_first_done_timeout", 0, 1);
    a3 = 3'b010; b3 = 3'b011; md = 2'b01;
    @(posedge clk);
    #1;
    push_exp(0, 3'b010, 3'b011, 8'h00, 8'h00, 2'b01);
    st = '0;
    chk("b2b_busy_no_idle", int'(bz[0]), 1);
    drain();

    // Inputs toggled during SCAN must not disturb the latched operation.
    start_op(5'b00011, 3'b011, 3'b010, 8'h00, 8'h00, 2'b01, 1'b1);
    @(negedge clk);
    st = 5'b00011; a3 = 3'b000; md = 2'b00;
    @(negedge clk);
    st = '0; a3 = 3'b001; b3 = 3'b111;
    drain();
    repeat (4) @(negedge clk);

    // Exhaustive N=3 sweep; 8-bit units take random operands alongside.
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) begin
          start_op(5'b11111, 3'(a), 3'(b), 8'($urandom), 8'($urandom), 2'(m), 1'b1);
          drain();
        end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
